// File: rtl/sysex_patch_sender.sv
// SysEx patch-dump transmitter: walks parameter memory and streams F0 .. F7 to the MIDI TX UART.
// Optional checksum byte before F7 when SYX_CHECKSUM_EN is defined.
//
// state  | meaning
// IDLE   | waiting for send_req
// HDR    | sending F0, MANUF_ID, dev_id, 01
// FETCH  | read strobe for parameter idx
// WAIT   | capture memory data
// SEND   | offer data byte until accepted
// CKSUM  | offer checksum byte (checksum build only)
// EOX    | offer F7
// DONE   | one-cycle done pulse
module sysex_patch_sender #(
    parameter logic [7:0] MANUF_ID   = 8'h7D,
    parameter int         NUM_PARAMS = 128,
    parameter int         ADDR_W     = 7
) (
    input  logic              reg_clk,
    input  logic              reset_reg_N,
    input  logic              send_req,
    input  logic [3:0]        dev_id,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_en,
    input  logic [7:0]        rd_data,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              dec_sysex_data_patch_send,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_FETCH, S_WAIT, S_SEND, S_CKSUM, S_EOX, S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_PARAMS - 1);

    state_t            state, state_nxt;
    logic [1:0]        hdr_idx;
    logic [ADDR_W-1:0] idx;
    logic [7:0]        data_q;
    logic [3:0]        dev_q;
    logic              start;

`ifdef SYX_CHECKSUM_EN
    logic [6:0] sum;
    logic [6:0] cksum;
    assign cksum = 7'd0 - sum;
`endif

    assign start = (state == S_IDLE) && send_req;

    always_ff @(posedge reg_clk or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        tx_valid  = 1'b0;
        tx_data   = 8'h00;
        rd_en     = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (send_req) state_nxt = S_HDR;
            end
            S_HDR: begin
                tx_valid = 1'b1;
                unique case (hdr_idx)
                    2'd0: tx_data = 8'hF0;
                    2'd1: tx_data = MANUF_ID;
                    2'd2: tx_data = {4'h0, dev_q};
                    default: tx_data = 8'h01;
                endcase
                if (tx_ready && hdr_idx == 2'd3) state_nxt = S_FETCH;
            end
            S_FETCH: begin
                rd_en     = 1'b1;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                state_nxt = S_SEND;
            end
            S_SEND: begin
                tx_valid = 1'b1;
                tx_data  = data_q;
                if (tx_ready) begin
                    if (idx == LAST_IDX) begin
`ifdef SYX_CHECKSUM_EN
                        state_nxt = S_CKSUM;
`else
                        state_nxt = S_EOX;
`endif
                    end else begin
                        state_nxt = S_FETCH;
                    end
                end
            end
            S_CKSUM: begin
                tx_valid = 1'b1;
`ifdef SYX_CHECKSUM_EN
                tx_data  = {1'b0, cksum};
`endif
                if (tx_ready) state_nxt = S_EOX;
            end
            S_EOX: begin
                tx_valid = 1'b1;
                tx_data  = 8'hF7;
                if (tx_ready) state_nxt = S_DONE;
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge reg_clk or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            hdr_idx <= 2'd0;
            idx     <= '0;
            data_q  <= 8'h00;
            dev_q   <= 4'h0;
`ifdef SYX_CHECKSUM_EN
            sum     <= 7'd0;
`endif
        end else begin
            if (start) begin
                hdr_idx <= 2'd0;
                idx     <= '0;
                dev_q   <= dev_id;
`ifdef SYX_CHECKSUM_EN
                sum     <= 7'd0;
`endif
            end
            if (state == S_HDR && tx_ready) hdr_idx <= hdr_idx + 2'd1;
            if (state == S_WAIT) begin
                data_q <= rd_data & 8'h7F;
`ifdef SYX_CHECKSUM_EN
                sum    <= sum + rd_data[6:0];
`endif
            end
            // idx stops at the last address so a full 2**ADDR_W dump never wraps
            if (state == S_SEND && tx_ready && idx != LAST_IDX) idx <= idx + ADDR_W'(1);
        end
    end

    assign rd_addr                   = idx;
    assign busy                      = (state != S_IDLE);
    assign done                      = (state == S_DONE);
    assign dec_sysex_data_patch_send = (state != S_IDLE) && (state != S_DONE);

endmodule
